// File: rtl/logicnet_lut_neuron_prog.sv
// Programmable LogicNet neuron bank: one runtime-loadable truth table per channel,
// looked up through a two-stage valid/ready pipeline. Tables are zeroed after every reset.
module logicnet_lut_neuron_prog #(
    parameter int FAN_IN   = 3,
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 2,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = FAN_IN * IN_BITS,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [ADDR_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [OUT_BITS-1:0] out_data,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_err,
    output logic                busy
);

    localparam int DEPTH = 1 << ADDR_W;
    // SEL_W addresses the physical tables; CH_W may be wider so that
    // out-of-range channel numbers can be presented and rejected.
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW    = SEL_W + ADDR_W;
    localparam logic [SW-1:0] SWEEP_LAST = SW'(CHANNELS * DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   sweep_reg, sweep_next;

    logic                a_valid_reg;
    logic [CH_W-1:0]     a_ch_reg;
    logic [ADDR_W-1:0]   a_addr_reg;
    logic                b_valid_reg;
    logic [CH_W-1:0]     b_ch_reg;
    logic                b_hit_reg;
    logic [SEL_W-1:0]    b_sel_reg;
    logic                cfg_err_reg;

    logic                clearing;
    logic                advance;
    logic                accept;
    logic                a_ok;
    logic [SEL_W-1:0]    a_sel;
    logic                rd_en;
    logic                cfg_ok;
    logic                wr_any;
    logic [SEL_W-1:0]    wr_sel;
    logic [ADDR_W-1:0]   wr_addr;
    logic [OUT_BITS-1:0] wr_data;
    logic [CHANNELS*OUT_BITS-1:0] rd_bus;

    function automatic logic ch_ok(input logic [CH_W-1:0] ch);
        return {{(32-CH_W){1'b0}}, ch} < 32'(CHANNELS);
    endfunction

    // ---------------- clear / run sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CLEAR;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        case (state_reg)
            CLEAR: begin
                if (sweep_reg == SWEEP_LAST) begin
                    state_next = RUN;
                    sweep_next = '0;
                end else begin
                    sweep_next = sweep_reg + SW'(1);
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
                sweep_next = '0;
            end
        endcase
    end

    assign clearing = (state_reg == CLEAR);
    assign busy     = clearing;

    // ---------------- shared table write port ----------------
    assign cfg_ok  = cfg_we & ~clearing & ch_ok(cfg_ch);
    assign wr_any  = clearing | cfg_ok;
    assign wr_sel  = clearing ? sweep_reg[SW-1:ADDR_W] : SEL_W'(cfg_ch);
    assign wr_addr = clearing ? sweep_reg[ADDR_W-1:0] : cfg_addr;
    assign wr_data = clearing ? '0 : cfg_data;

    // ---------------- pipeline control ----------------
    assign advance  = ~b_valid_reg | out_ready;
    assign in_ready = (state_reg == RUN) & advance;
    assign accept   = in_valid & in_ready;
    assign a_ok     = ch_ok(a_ch_reg);
    assign a_sel    = SEL_W'(a_ch_reg);
    assign rd_en    = advance & a_valid_reg & a_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_reg <= 1'b0;
            a_ch_reg    <= '0;
            a_addr_reg  <= '0;
            b_valid_reg <= 1'b0;
            b_ch_reg    <= '0;
            b_hit_reg   <= 1'b0;
            b_sel_reg   <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_we & (clearing | ~ch_ok(cfg_ch));
            if (advance) begin
                a_valid_reg <= accept;
                if (accept) begin
                    a_ch_reg   <= in_ch;
                    a_addr_reg <= in_data;
                end
                b_valid_reg <= a_valid_reg;
                // Payload only moves with a valid beat so idle outputs never show stale RAM contents.
                if (a_valid_reg) begin
                    b_ch_reg  <= a_ch_reg;
                    b_hit_reg <= a_ok;
                    b_sel_reg <= a_sel;
                end
            end
        end
    end

    // ---------------- per-channel tables ----------------
    // Read and write share one block, so a same-edge collision returns the old entry.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [OUT_BITS-1:0] mem [DEPTH];
        logic [OUT_BITS-1:0] rd_reg;

        always_ff @(posedge clk) begin
            if (wr_any && (wr_sel == SEL_W'(gi))) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en && (a_sel == SEL_W'(gi))) begin
                rd_reg <= mem[a_addr_reg];
            end
        end

        assign rd_bus[gi*OUT_BITS +: OUT_BITS] = rd_reg;
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (b_hit_reg && (b_sel_reg == SEL_W'(c))) begin
                out_data = rd_bus[c*OUT_BITS +: OUT_BITS];
            end
        end
    end

    assign out_valid = b_valid_reg;
    assign out_ch    = b_ch_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_logicnet_lut_neuron_prog.sv
// Directed/table-driven bench for logicnet_lut_neuron_prog (3-bit channel field,
// so channels 4..7 exercise the out-of-range paths).
module tb_logicnet_lut_neuron_prog;

    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_ch, out_ch, cfg_ch;
    logic [5:0] in_data, cfg_addr;
    logic [1:0] out_data, cfg_data;
    logic       cfg_we, cfg_err, busy;

    logicnet_lut_neuron_prog #(
        .FAN_IN(3), .IN_BITS(2), .OUT_BITS(2), .CHANNELS(4), .CH_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch;
        logic [5:0] addr;
        logic [1:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0] ch;
        logic [1:0] exp;
        int         cyc;
    } pend_t;

    vec_t  req_q[$];
    pend_t pend_q[$];
    vec_t  vec_tab[10];
    logic [1:0] model [8][64];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // f(a,b,c) = min(3, a*b + c), a = bits[1:0], b = bits[3:2], c = bits[5:4]
    function automatic logic [1:0] f0(input logic [5:0] ad);
        int v;
        v = int'(ad[1:0]) * int'(ad[3:2]) + int'(ad[5:4]);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    task automatic zero_model();
        for (int c = 0; c < 8; c++)
            for (int a = 0; a < 64; a++)
                model[c][a] = 2'd0;
    endtask

    task automatic push(input logic [2:0] ch, input logic [5:0] addr);
        req_q.push_back('{ch, addr, model[ch][addr]});
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [5:0] addr, input logic [1:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
        if (ch < 3'd4) model[ch][addr] = data;
    endtask

    task automatic cfg_idle();
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Counts edges after rst release until busy drops; optionally injects a write mid-clear.
    task automatic wait_clear(input bit inject);
        int  n = 0;
        bit  done = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) begin
                done = 1;
            end else begin
                check("ready_in_clear", 32'(in_ready), 32'd0);
                if (inject && n == 200) begin
                    cfg_we = 1'b1; cfg_ch = 3'd2; cfg_addr = 6'd5; cfg_data = 2'd3;
                end
                if (inject && n == 201) begin
                    check("cfg_err_clear", 32'(cfg_err), 32'd1);
                    cfg_we = 1'b0;
                end
                if (inject && n == 202) check("cfg_err_clear_pulse", 32'(cfg_err), 32'd0);
            end
        end
        check("busy_cycles", 32'(n), 32'd256);
        check("ready_after_clear", 32'(in_ready), 32'd1);
    endtask

    // Streams req_q through the DUT with out_ready asserted rdy_pct% of cycles.
    task automatic run_stream(input int rdy_pct, input bit chk_lat);
        int         idx = 0;
        int         cyc = 0;
        int         budget;
        bit         held = 0;
        logic [2:0] hc;
        logic [1:0] hd;
        pend_t      p;
        budget = 20 * req_q.size() + 50;
        while ((idx < req_q.size() || pend_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            if (held) check("stall_hold", 32'({out_valid, out_ch, out_data}), 32'({1'b1, hc, hd}));
            out_ready = ($urandom_range(99) < rdy_pct);
            if (idx < req_q.size()) begin
                in_valid = 1'b1; in_ch = req_q[idx].ch; in_data = req_q[idx].addr;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (pend_q.size() == 0) begin
                    check("extra_output", 32'({out_ch, out_data}), 32'hFFFF);
                end else begin
                    p = pend_q.pop_front();
                    check("lookup", 32'({out_ch, out_data}), 32'({p.ch, p.exp}));
                    if (chk_lat) check("latency", 32'(cyc - p.cyc), 32'd2);
                end
            end
            held = out_valid && !out_ready;
            hc = out_ch;
            hd = out_data;
            if (in_valid && in_ready) begin
                pend_q.push_back('{req_q[idx].ch, req_q[idx].exp, cyc});
                idx++;
            end
            cyc++;
        end
        if (cyc >= budget) begin
            total++; bad++;
            $display("FAIL stream_timeout: got %0d pending, want 0", pend_q.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("drain_empty", 32'(out_valid), 32'd0);
        req_q.delete();
        pend_q.delete();
    endtask

    initial begin
        in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
        zero_model();

        // {ch, addr = {c,b,a}, expected}
        vec_tab[0] = '{3'd0, 6'd6,  2'd2};  // a=2 b=1 c=0
        vec_tab[1] = '{3'd0, 6'd15, 2'd3};  // a=3 b=3 c=0 -> 9 saturates
        vec_tab[2] = '{3'd0, 6'd21, 2'd2};  // a=1 b=1 c=1
        vec_tab[3] = '{3'd0, 6'd28, 2'd1};  // a=0 b=3 c=1
        vec_tab[4] = '{3'd3, 6'd6,  2'd1};
        vec_tab[5] = '{3'd3, 6'd21, 2'd1};
        vec_tab[6] = '{3'd3, 6'd0,  2'd3};
        vec_tab[7] = '{3'd3, 6'd28, 2'd2};
        vec_tab[8] = '{3'd5, 6'd6,  2'd0};  // out-of-range channel
        vec_tab[9] = '{3'd1, 6'd6,  2'd0};  // never written

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_ch",    32'(out_ch),    32'd0);
        check("rst_cfg_err",   32'(cfg_err),   32'd0);
        check("rst_busy",      32'(busy),      32'd1);
        check("rst_in_ready",  32'(in_ready),  32'd0);

        @(negedge clk);
        rst = 1'b0;
        wait_clear(1'b0);

        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 64; a++)
                push(3'(c), 6'(a));
        run_stream(100, 1'b1);

        for (int a = 0; a < 64; a++) begin
            cfg_write(3'd0, 6'(a), f0(6'(a)));
            cfg_write(3'd3, 6'(a), ~f0(6'(a)));
        end
        cfg_idle();

        for (int a = 0; a < 64; a++) begin
            push(3'd0, 6'(a));
            push(3'd3, 6'(a));
        end
        run_stream(100, 1'b1);

        for (int i = 0; i < 10; i++) req_q.push_back(vec_tab[i]);
        run_stream(100, 1'b1);

        // Collision: write lands on the same edge that stage B reads the entry
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_ch = 3'd1; in_data = 6'b110100;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_addr = 6'b110100; cfg_data = 2'b11;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        check("collision_old", 32'({out_valid, out_data}), 32'({1'b1, 2'b00}));
        check("valid_write_no_err", 32'(cfg_err), 32'd0);
        model[1][52] = 2'b11;
        req_q.push_back('{3'd1, 6'b110100, 2'b11});
        run_stream(100, 1'b1);

        // Out-of-range config channel
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 3'd4; cfg_addr = 6'd63; cfg_data = 2'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        check("cfg_err_badch", 32'(cfg_err), 32'd1);
        @(negedge clk);
        #1;
        check("cfg_err_badch_pulse", 32'(cfg_err), 32'd0);
        req_q.push_back('{3'd0, 6'd63, 2'd3});
        req_q.push_back('{3'd4, 6'd63, 2'd0});
        run_stream(100, 1'b1);

        // Random backpressure
        for (int i = 0; i < 1000; i++) push(3'($urandom_range(7)), 6'($urandom_range(63)));
        run_stream(50, 1'b0);

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_ch = 3'd0; in_data = 6'd6;
        @(negedge clk);
        in_data = 6'd15;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("fill_b_valid", 32'(out_valid), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy",      32'(busy),      32'd1);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        wait_clear(1'b1);
        zero_model();

        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 64; a++)
                push(3'(c), 6'(a));
        run_stream(100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
